key_search_ctrl: RTL and testbench

//  Upstream controller for decryption_core: brute-forces the secret key.
//  For each candidate it resets the core, pulses start with the key, and waits for done.
//  It then scans the decrypted-message RAM and accepts the key if every byte is 'a'..'z' or space.

---
 rtl/key_search_pkg.sv | 30 +++
 rtl/msg_scanner.sv | 81 ++++++++
 rtl/key_search_ctrl.sv | 169 ++++++++++++++++
 tb/tb_key_search_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_search_pkg.sv
// Shared types and character-class helper for the key search controller.
package key_search_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRST,
    ST_CRUN,
    ST_SCAN,
    ST_NEXT,
    ST_FOUND,
    ST_FAIL,
    ST_ERR
  } ks_state_t;

  typedef enum logic [1:0] {
    SC_IDLE,
    SC_RD,
    SC_EVAL
  } sc_state_t;

  localparam logic [7:0] CHAR_LO = 8'h61;
  localparam logic [7:0] CHAR_HI = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  // Lower-case letter or space; comparisons are on unsigned bytes.
  function automatic logic is_plain_char(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SP);
  endfunction

endpackage

// File: rtl/msg_scanner.sv
// Walks the decrypted-message RAM one byte at a time, 3 cycles per byte, and
// reports pass/fail on the first bad byte or after the last byte.
module msg_scanner
  import key_search_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] dmsg_addr,
  input  logic [7:0]        dmsg_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

  sc_state_t         state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              wait_cnt, wait_cnt_nxt;
  logic              byte_ok;
  logic              last_byte;

  assign byte_ok   = is_plain_char(dmsg_rdata);
  assign last_byte = (dmsg_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= SC_IDLE;
      dmsg_addr <= '0;
      wait_cnt  <= 1'b0;
    end else begin
      state     <= state_nxt;
      dmsg_addr <= addr_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    addr_nxt     = dmsg_addr;
    wait_cnt_nxt = wait_cnt;
    done         = 1'b0;
    pass         = 1'b0;
    case (state)
      SC_IDLE: begin
        if (go) begin
          addr_nxt     = '0;
          wait_cnt_nxt = 1'b0;
          state_nxt    = SC_RD;
        end
      end
      // Two cycles: one for the RAM address register, one for its q register.
      SC_RD: begin
        if (wait_cnt) begin
          state_nxt = SC_EVAL;
        end else begin
          wait_cnt_nxt = 1'b1;
        end
      end
      SC_EVAL: begin
        if (!byte_ok) begin
          done      = 1'b1;
          state_nxt = SC_IDLE;
        end else if (last_byte) begin
          done      = 1'b1;
          pass      = 1'b1;
          state_nxt = SC_IDLE;
        end else begin
          addr_nxt     = dmsg_addr + 1'b1;
          wait_cnt_nxt = 1'b0;
          state_nxt    = SC_RD;
        end
      end
      default: state_nxt = SC_IDLE;
    endcase
  end

endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force key search: resets and runs the decryption core per candidate key,
// then has msg_scanner vet the plaintext; stops on first plain-text key or range end.
module key_search_ctrl
  import key_search_pkg::*;
#(
  parameter int KEY_W       = 10,
  parameter int MSG_LEN     = 32,
  parameter int ADDR_W      = 5,
  parameter int KEY_FIRST   = 0,
  parameter int KEY_LAST    = 1023,
  parameter int RST_CYC     = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              search_start,
  output logic              core_rst_n,
  output logic              core_start,
  output logic [KEY_W-1:0]  core_key,
  input  logic              core_done,
  output logic [ADDR_W-1:0] dmsg_addr,
  input  logic [7:0]        dmsg_rdata,
  output logic              busy,
  output logic              found,
  output logic              exhausted,
  output logic              timeout_err,
  output logic [KEY_W-1:0]  found_key
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYC - 1);
  localparam logic [KEY_W-1:0] K_FIRST = KEY_W'(KEY_FIRST);
  localparam logic [KEY_W-1:0] K_LAST  = KEY_W'(KEY_LAST);

  ks_state_t        state, state_nxt;
  logic [RC_W-1:0]  rst_cnt, rst_cnt_nxt;
  logic [WD_W-1:0]  wd_cnt, wd_cnt_nxt;
  logic [KEY_W-1:0] key_nxt, found_key_nxt;
  logic             core_rst_n_nxt, core_start_nxt;
  logic             busy_nxt, found_nxt, exhausted_nxt, timeout_nxt;
  logic             scan_go, scan_done, scan_pass;

  msg_scanner #(
    .MSG_LEN (MSG_LEN),
    .ADDR_W  (ADDR_W)
  ) u_scanner (
    .clk        (clk),
    .reset_n    (reset_n),
    .go         (scan_go),
    .done       (scan_done),
    .pass       (scan_pass),
    .dmsg_addr  (dmsg_addr),
    .dmsg_rdata (dmsg_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rst_cnt     <= '0;
      wd_cnt      <= '0;
      core_rst_n  <= 1'b0;
      core_start  <= 1'b0;
      core_key    <= K_FIRST;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      timeout_err <= 1'b0;
      found_key   <= '0;
    end else begin
      state       <= state_nxt;
      rst_cnt     <= rst_cnt_nxt;
      wd_cnt      <= wd_cnt_nxt;
      core_rst_n  <= core_rst_n_nxt;
      core_start  <= core_start_nxt;
      core_key    <= key_nxt;
      busy        <= busy_nxt;
      found       <= found_nxt;
      exhausted   <= exhausted_nxt;
      timeout_err <= timeout_nxt;
      found_key   <= found_key_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    rst_cnt_nxt    = rst_cnt;
    wd_cnt_nxt     = wd_cnt;
    core_rst_n_nxt = core_rst_n;
    core_start_nxt = core_start;
    key_nxt        = core_key;
    busy_nxt       = busy;
    found_nxt      = found;
    exhausted_nxt  = exhausted;
    timeout_nxt    = timeout_err;
    found_key_nxt  = found_key;
    scan_go        = 1'b0;
    case (state)
      // Terminal states restart exactly like IDLE.
      ST_IDLE, ST_FOUND, ST_FAIL, ST_ERR: begin
        if (search_start) begin
          state_nxt      = ST_CRST;
          key_nxt        = K_FIRST;
          rst_cnt_nxt    = '0;
          core_rst_n_nxt = 1'b0;
          core_start_nxt = 1'b0;
          busy_nxt       = 1'b1;
          found_nxt      = 1'b0;
          exhausted_nxt  = 1'b0;
          timeout_nxt    = 1'b0;
          found_key_nxt  = '0;
        end
      end
      ST_CRST: begin
        if (rst_cnt == RC_LAST) begin
          state_nxt      = ST_CRUN;
          core_rst_n_nxt = 1'b1;
          core_start_nxt = 1'b1;
          wd_cnt_nxt     = '0;
        end else begin
          rst_cnt_nxt = rst_cnt + 1'b1;
        end
      end
      // A done arriving on the last watchdog cycle still counts as success.
      ST_CRUN: begin
        if (core_done) begin
          core_start_nxt = 1'b0;
          scan_go        = 1'b1;
          state_nxt      = ST_SCAN;
        end else if (wd_cnt == WD_LAST) begin
          core_start_nxt = 1'b0;
          timeout_nxt    = 1'b1;
          busy_nxt       = 1'b0;
          state_nxt      = ST_ERR;
        end else begin
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
      end
      ST_SCAN: begin
        if (scan_done) begin
          if (scan_pass) begin
            found_nxt     = 1'b1;
            found_key_nxt = core_key;
            busy_nxt      = 1'b0;
            state_nxt     = ST_FOUND;
          end else begin
            state_nxt = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (core_key == K_LAST) begin
          exhausted_nxt = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = ST_FAIL;
        end else begin
          key_nxt        = core_key + 1'b1;
          rst_cnt_nxt    = '0;
          core_rst_n_nxt = 1'b0;
          state_nxt      = ST_CRST;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench: behavioural decryption core + registered-read message RAM per DUT.
module tb_key_search_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  int         total = 0;
  int         bad = 0;

  // Main DUT (full key range, short watchdog)
  logic       search_start = 1'b0;
  logic       core_rst_n, core_start, core_done = 1'b0;
  logic [9:0] core_key, found_key;
  logic [4:0] dmsg_addr;
  logic [7:0] dmsg_rdata = 8'h00;
  logic       busy, found, exhausted, timeout_err;

  // Second DUT for the top-of-range case
  logic       search_start_b = 1'b0;
  logic       core_rst_n_b, core_start_b, core_done_b = 1'b0;
  logic [9:0] core_key_b, found_key_b;
  logic [4:0] dmsg_addr_b;
  logic [7:0] dmsg_rdata_b = 8'h00;
  logic       busy_b, found_b, exhausted_b, timeout_err_b;

  int mode = 0;
  int lat = 50;
  int lat_b = 20;
  bit no_done = 1'b0;
  int cc = 0, cc_b = 0;

  int low_run = 0, rises = 0, crun_cyc = 0;
  int low_run_b = 0, rises_b = 0;
  int rst_len [16];
  int max_addr [16];

  always #5 clk = ~clk;

  key_search_ctrl #(.TIMEOUT_CYC(100)) u_dut (
    .clk(clk), .reset_n(reset_n), .search_start(search_start),
    .core_rst_n(core_rst_n), .core_start(core_start), .core_key(core_key),
    .core_done(core_done), .dmsg_addr(dmsg_addr), .dmsg_rdata(dmsg_rdata),
    .busy(busy), .found(found), .exhausted(exhausted),
    .timeout_err(timeout_err), .found_key(found_key)
  );

  key_search_ctrl #(.KEY_FIRST(1020), .KEY_LAST(1023), .TIMEOUT_CYC(100)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .search_start(search_start_b),
    .core_rst_n(core_rst_n_b), .core_start(core_start_b), .core_key(core_key_b),
    .core_done(core_done_b), .dmsg_addr(dmsg_addr_b), .dmsg_rdata(dmsg_rdata_b),
    .busy(busy_b), .found(found_b), .exhausted(exhausted_b),
    .timeout_err(timeout_err_b), .found_key(found_key_b)
  );

  // Plaintext pattern cycles through the class boundaries 'a', 'z', ' '.
  function automatic logic [7:0] msg_byte(input int m, input logic [9:0] k, input logic [4:0] a);
    logic [7:0] b;
    case (int'(a) % 3)
      0:       b = 8'h61;
      1:       b = 8'h7A;
      default: b = 8'h20;
    endcase
    case (m)
      0: if (k != 10'd3 && a == 5'd0) b = 8'h41;
      1: begin
        case (k)
          10'd0: if (a == 5'd31) b = 8'h7B;
          10'd1: if (a == 5'd5)  b = 8'h60;
          10'd2: if (a == 5'd0)  b = 8'h21;
          10'd3: if (a == 5'd0)  b = 8'h1F;
          10'd4: if (a == 5'd0)  b = 8'hE1;
          default: ;
        endcase
      end
      2: if (k != 10'd6 && a == 5'd0) b = 8'h41;
      default: if (a == 5'd0) b = 8'h41;
    endcase
    return b;
  endfunction

  always @(posedge clk) begin
    if (core_rst_n === 1'b0) begin
      cc <= 0;
      core_done <= 1'b0;
    end else if (core_start === 1'b1 && !no_done && !core_done) begin
      if (cc == lat - 1) core_done <= 1'b1;
      cc <= cc + 1;
    end
    dmsg_rdata <= msg_byte(mode, core_key, dmsg_addr);
  end

  always @(posedge clk) begin
    if (core_rst_n_b === 1'b0) begin
      cc_b <= 0;
      core_done_b <= 1'b0;
    end else if (core_start_b === 1'b1 && !core_done_b) begin
      if (cc_b == lat_b - 1) core_done_b <= 1'b1;
      cc_b <= cc_b + 1;
    end
    dmsg_rdata_b <= msg_byte(3, core_key_b, dmsg_addr_b);
  end

  always @(negedge clk) begin
    if (core_rst_n === 1'b0) begin
      low_run = low_run + 1;
    end else begin
      if (low_run > 0) begin
        rises = rises + 1;
        rst_len[core_key[3:0]] = low_run;
      end
      low_run = 0;
    end
    if (busy === 1'b1 && core_rst_n === 1'b1 && core_start === 1'b0)
      if (int'(dmsg_addr) > max_addr[core_key[3:0]]) max_addr[core_key[3:0]] = int'(dmsg_addr);
    if (core_start === 1'b1) crun_cyc = crun_cyc + 1;
    if (core_rst_n_b === 1'b0) begin
      low_run_b = low_run_b + 1;
    end else begin
      if (low_run_b > 0) rises_b = rises_b + 1;
      low_run_b = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    rises = 0;
    crun_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      rst_len[i] = 0;
      max_addr[i] = -1;
    end
  endtask

  task automatic pulse_start();
    search_start = 1'b1;
    tick();
    search_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      tick();
      n++;
    end
    chk(tag, (n < 5000), 1);
  endtask

  initial begin
    int n;
    clr_mon();
    tick(3);

    // Reset state
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_dmsg_addr", dmsg_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_found", found, 0);
    chk("rst_exhausted", exhausted, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_found_key", found_key, 0);
    chk("rst_b_core_key", core_key_b, 1020);
    reset_n = 1'b1;
    tick(2);

    // Top-of-range exhaustion without wrap
    rises_b = 0;
    search_start_b = 1'b1;
    tick();
    search_start_b = 1'b0;
    n = 0;
    while (exhausted_b !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    chk("exh_wait", (n < 5000), 1);
    chk("exh_keys_tried", rises_b, 4);
    chk("exh_flag", exhausted_b, 1);
    chk("exh_busy", busy_b, 0);
    chk("exh_found", found_b, 0);
    chk("exh_key_end", core_key_b, 1023);
    tick(20);
    chk("exh_key_hold", core_key_b, 1023);

    // Key 3 is the only plaintext key
    mode = 0;
    clr_mon();
    pulse_start();
    chk("t1_busy_start", busy, 1);
    wait_idle("t1_wait");
    chk("t1_found", found, 1);
    chk("t1_found_key", found_key, 3);
    chk("t1_busy", busy, 0);
    chk("t1_exhausted", exhausted, 0);
    chk("t1_keys_tried", rises, 4);
    chk("t1_rstlen_k1", rst_len[1], 2);
    chk("t1_rstlen_k2", rst_len[2], 2);
    chk("t1_rstlen_k3", rst_len[3], 2);
    chk("t1_core_rst_n_kept", core_rst_n, 1);
    // Wrong keys abort after byte 0
    chk("t2_maxaddr_k0", max_addr[0], 0);
    chk("t2_maxaddr_k1", max_addr[1], 0);
    chk("t2_maxaddr_k2", max_addr[2], 0);
    chk("t2_maxaddr_k3", max_addr[3], 31);

    // Character-class boundaries
    mode = 1;
    clr_mon();
    pulse_start();
    chk("t3_found_cleared", found, 0);
    wait_idle("t3_wait");
    chk("t3_found_key", found_key, 5);
    chk("t3_keys_tried", rises, 6);
    chk("t3_maxaddr_k0_7B", max_addr[0], 31);
    chk("t3_maxaddr_k1_60", max_addr[1], 5);
    chk("t3_maxaddr_k2_21", max_addr[2], 0);
    chk("t3_maxaddr_k3_1F", max_addr[3], 0);
    chk("t3_maxaddr_k4_E1", max_addr[4], 0);
    chk("t3_maxaddr_k5", max_addr[5], 31);

    // Watchdog
    no_done = 1'b1;
    clr_mon();
    pulse_start();
    wait_idle("t5_wait");
    chk("t5_timeout", timeout_err, 1);
    chk("t5_busy", busy, 0);
    chk("t5_crun_cycles", crun_cyc, 100);
    chk("t5_found", found, 0);
    chk("t5_core_key", core_key, 0);
    chk("t5_core_start", core_start, 0);
    no_done = 1'b0;

    // Mid-search start is ignored, then sync reset during EVAL of key 5
    mode = 2;
    pulse_start();
    chk("t6_timeout_cleared", timeout_err, 0);
    n = 0;
    while (!(core_key == 10'd2 && core_start === 1'b1) && n < 5000) begin
      tick();
      n++;
    end
    chk("t6_wait_k2", (n < 5000), 1);
    pulse_start();
    chk("t6_ign_core_key", core_key, 2);
    chk("t6_ign_busy", busy, 1);
    chk("t6_ign_core_rst_n", core_rst_n, 1);
    chk("t6_ign_core_start", core_start, 1);
    n = 0;
    while (!(core_key == 10'd5 && busy === 1'b1 && core_rst_n === 1'b1 && core_start === 1'b0) && n < 5000) begin
      tick();
      n++;
    end
    chk("t6_wait_k5", (n < 5000), 1);
    tick(2);
    reset_n = 1'b0;
    tick();
    chk("t6_rst_core_rst_n", core_rst_n, 0);
    chk("t6_rst_core_start", core_start, 0);
    chk("t6_rst_core_key", core_key, 0);
    chk("t6_rst_dmsg_addr", dmsg_addr, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_found", found, 0);
    chk("t6_rst_found_key", found_key, 0);
    reset_n = 1'b1;
    tick(5);
    chk("t6_idle_busy", busy, 0);
    pulse_start();
    wait_idle("t6_wait_found");
    chk("t6_found", found, 1);
    chk("t6_found_key", found_key, 6);
    pulse_start();
    chk("t6_restart_found", found, 0);
    chk("t6_restart_busy", busy, 1);
    chk("t6_restart_key", core_key, 0);
    chk("t6_restart_core_rst_n", core_rst_n, 0);
    wait_idle("t6_wait_found2");
    chk("t6_found_key2", found_key, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
